// File: rtl/regfile_param.sv
// Two-read/one-write register file with a zero register, write bypass,
// a busy scoreboard and a one-entry-per-cycle bulk-clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegNo,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegNo,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              ClearReq,
  output logic              Ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic wr_en, rsv_en, byp_ok;
  logic zero1, zero2, byp1, byp2;

  assign Ready  = (state_q == IDLE);
  assign wr_en  = RegWrite && Ready &&
                  !((ZERO_REG != 0) && (WriteRegNo == '0));
  assign rsv_en = Reserve && Ready &&
                  !((ZERO_REG != 0) && (ReserveRegNo == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          regs_d[WriteRegNo] = WriteData;
          busy_d[WriteRegNo] = 1'b0;
        end
        // reserve after write: a pending producer keeps the entry busy
        if (rsv_en) begin
          busy_d[ReserveRegNo] = 1'b1;
        end
        if (ClearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  assign byp_ok = (BYPASS != 0) && wr_en && !Reset;
  assign zero1  = (ZERO_REG != 0) && (ReadReg1 == '0);
  assign zero2  = (ZERO_REG != 0) && (ReadReg2 == '0);
  assign byp1   = byp_ok && (WriteRegNo == ReadReg1);
  assign byp2   = byp_ok && (WriteRegNo == ReadReg2);

  assign ReadData1 = zero1 ? '0 :
                     byp1  ? WriteData : regs_q[ReadReg1];
  assign ReadData2 = zero2 ? '0 :
                     byp2  ? WriteData : regs_q[ReadReg2];

  assign Busy1 = busy_q[ReadReg1];
  assign Busy2 = busy_q[ReadReg2];

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: a default instance (A) and a
// narrow, non-zero-reg, non-bypass instance (B) against an array model.
module tb_regfile_param;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  logic        we  [2];
  logic        rsv [2];
  logic        clr [2];
  logic [4:0]  wa  [2];
  logic [4:0]  ra1 [2];
  logic [4:0]  ra2 [2];
  logic [4:0]  rsa [2];
  logic [31:0] wd  [2];

  logic [31:0] rdA1, rdA2;
  logic [7:0]  rdB1, rdB2;
  logic        bA1, bA2, bB1, bB2, rdyA, rdyB;

  regfile_param dutA (
    .Clock(Clock), .Reset(Reset),
    .RegWrite(we[0]), .WriteRegNo(wa[0]), .WriteData(wd[0]),
    .ReadReg1(ra1[0]), .ReadReg2(ra2[0]),
    .ReadData1(rdA1), .ReadData2(rdA2),
    .Reserve(rsv[0]), .ReserveRegNo(rsa[0]),
    .Busy1(bA1), .Busy2(bA2),
    .ClearReq(clr[0]), .Ready(rdyA)
  );

  regfile_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .Clock(Clock), .Reset(Reset),
    .RegWrite(we[1]), .WriteRegNo(wa[1][2:0]), .WriteData(wd[1][7:0]),
    .ReadReg1(ra1[1][2:0]), .ReadReg2(ra2[1][2:0]),
    .ReadData1(rdB1), .ReadData2(rdB2),
    .Reserve(rsv[1]), .ReserveRegNo(rsa[1][2:0]),
    .Busy1(bB1), .Busy2(bB2),
    .ClearReq(clr[1]), .Ready(rdyB)
  );

  // ---------------- reference model ----------------
  logic [31:0] m  [2][32];
  bit          bz [2][32];
  int          sweep [2];

  function automatic int dep(int i);
    return (i == 0) ? 32 : 8;
  endfunction
  function automatic bit zr(int i);
    return i == 0;
  endfunction
  function automatic bit byp(int i);
    return i == 0;
  endfunction
  function automatic logic [31:0] mask(int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sweep[i] = -1;
      for (int j = 0; j < 32; j++) begin
        m[i][j]  = '0;
        bz[i][j] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(int i, logic [4:0] ra);
    if (Reset) return '0;
    if (zr(i) && ra == 0) return '0;
    if (byp(i) && sweep[i] < 0 && we[i] &&
        !(zr(i) && wa[i] == 0) && wa[i] == ra)
      return wd[i] & mask(i);
    return m[i][ra];
  endfunction

  function automatic logic [31:0] exp_busy(int i, logic [4:0] ra);
    if (Reset) return '0;
    return {31'd0, bz[i][ra]};
  endfunction

  always @(posedge Reset) model_reset();

  always @(posedge Clock) begin
    if (Reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sweep[i] >= 0) begin
          m[i][sweep[i]]  = '0;
          bz[i][sweep[i]] = 1'b0;
          sweep[i]++;
          if (sweep[i] == dep(i)) sweep[i] = -1;
        end else begin
          if (we[i] && !(zr(i) && wa[i] == 0)) begin
            m[i][wa[i]]  = wd[i] & mask(i);
            bz[i][wa[i]] = 1'b0;
          end
          if (rsv[i] && !(zr(i) && rsa[i] == 0))
            bz[i][rsa[i]] = 1'b1;
          if (clr[i]) sweep[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    chk("A.rd1", rdA1, exp_rd(0, ra1[0]));
    chk("A.rd2", rdA2, exp_rd(0, ra2[0]));
    chk("A.busy1", {31'd0, bA1}, exp_busy(0, ra1[0]));
    chk("A.busy2", {31'd0, bA2}, exp_busy(0, ra2[0]));
    chk("A.ready", {31'd0, rdyA}, {31'd0, sweep[0] < 0});
    chk("B.rd1", {24'd0, rdB1}, exp_rd(1, ra1[1]));
    chk("B.rd2", {24'd0, rdB2}, exp_rd(1, ra2[1]));
    chk("B.busy1", {31'd0, bB1}, exp_busy(1, ra1[1]));
    chk("B.busy2", {31'd0, bB2}, exp_busy(1, ra2[1]));
    chk("B.ready", {31'd0, rdyB}, {31'd0, sweep[1] < 0});
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    for (int i = 0; i < 2; i++) begin
      we[i] = 0; rsv[i] = 0; clr[i] = 0;
      wa[i] = 0; ra1[i] = 0; ra2[i] = 0; rsa[i] = 0; wd[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  logic [31:0] pre [32];

  initial begin
    model_reset();
    Reset = 1'b1;
    idle_in();
    #2;
    chk("rst.ready", {31'd0, rdyA}, 32'd1);
    chk("rst.rd", rdA1, 32'd0);
    step();
    step();
    Reset = 1'b0;

    // pairwise write / readback
    for (int n = 0; n < 32; n++) begin
      we[0] = 1; wa[0] = 5'(n); wd[0] = 32'(n + 1);
      we[1] = (n < 8); wa[1] = 5'(n % 8); wd[1] = 32'(n + 1);
      step();
    end
    idle_in();
    for (int n = 0; n < 32; n += 2) begin
      ra1[0] = 5'(n); ra2[0] = 5'(n + 1);
      ra1[1] = 5'(n % 8); ra2[1] = 5'((n + 1) % 8);
      #1;
      chk("s1.A.rd1", rdA1, (n == 0) ? 32'd0 : 32'(n + 1));
      chk("s1.A.rd2", rdA2, 32'(n + 2));
      if (n < 8) begin
        chk("s1.B.rd1", {24'd0, rdB1}, 32'(n + 1));
        chk("s1.B.rd2", {24'd0, rdB2}, 32'(n + 2));
      end
      step();
    end

    // bypass vs. no bypass
    idle_in();
    we[0] = 1; wa[0] = 5; wd[0] = 32'hDEAD_BEEF; ra1[0] = 5;
    we[1] = 1; wa[1] = 5; wd[1] = 32'hEF; ra1[1] = 5;
    #1;
    chk("s2.A.byp", rdA1, 32'hDEAD_BEEF);
    chk("s2.B.old", {24'd0, rdB1}, 32'd6);
    step();
    we[0] = 0; we[1] = 0;
    #1;
    chk("s2.B.new", {24'd0, rdB1}, 32'hEF);
    chk("s2.A.new", rdA1, 32'hDEAD_BEEF);

    // scoreboard
    idle_in();
    rsv[0] = 1; rsa[0] = 7; ra1[0] = 7;
    step();
    rsv[0] = 0;
    #1;
    chk("s3.rsv", {31'd0, bA1}, 32'd1);
    we[0] = 1; wa[0] = 7; wd[0] = 32'h77; rsv[0] = 1; rsa[0] = 7;
    step();
    idle_in(); ra1[0] = 7;
    #1;
    chk("s3.both.busy", {31'd0, bA1}, 32'd1);
    chk("s3.both.data", rdA1, 32'h77);
    we[0] = 1; wa[0] = 7; wd[0] = 32'h78;
    step();
    idle_in(); ra1[0] = 7;
    #1;
    chk("s3.wr.busy", {31'd0, bA1}, 32'd0);
    we[0] = 1; wa[0] = 10; wd[0] = 32'h1010; rsv[0] = 1; rsa[0] = 9;
    step();
    idle_in(); ra1[0] = 9; ra2[0] = 10;
    #1;
    chk("s3.diff.busy", {31'd0, bA1}, 32'd1);
    chk("s3.diff.data", rdA2, 32'h1010);

    // bulk clear with dropped writes
    idle_in();
    rsv[0] = 1; rsa[0] = 3; rsv[1] = 1; rsa[1] = 3;
    step();
    idle_in();
    clr[0] = 1; clr[1] = 1;
    we[0] = 1; wa[0] = 12; wd[0] = 32'hAAAA;
    step();
    idle_in();
    for (int k = 0; k < 32; k++) begin
      we[0] = 1; wa[0] = 5'($urandom_range(1, 31)); wd[0] = $urandom;
      rsv[0] = $urandom % 2; rsa[0] = 5'($urandom);
      clr[0] = $urandom % 2; ra1[0] = 5'($urandom);
      #1;
      chk("s4.notready", {31'd0, rdyA}, 32'd0);
      step();
    end
    idle_in();
    #1;
    chk("s4.ready", {31'd0, rdyA}, 32'd1);
    for (int n = 0; n < 32; n++) begin
      ra1[0] = 5'(n); ra2[0] = 5'(n); ra1[1] = 5'(n % 8);
      #1;
      chk("s4.zero", rdA1, 32'd0);
      chk("s4.idle", {31'd0, bA2}, 32'd0);
      step();
    end

    // async reset mid-sweep
    idle_in();
    for (int n = 1; n < 32; n++) begin
      pre[n] = $urandom | 32'h1;
      we[0] = 1; wa[0] = 5'(n); wd[0] = pre[n];
      step();
    end
    idle_in();
    clr[0] = 1;
    step();
    clr[0] = 0;
    for (int k = 0; k < 10; k++) step();
    ra1[0] = 20; ra2[0] = 10;
    #1;
    chk("s5.pre20", rdA1, pre[20]);
    chk("s5.pre10", rdA2, pre[10]);
    #1;
    Reset = 1'b1;
    #1;
    chk("s5.rst20", rdA1, 32'd0);
    chk("s5.rst10", rdA2, 32'd0);
    chk("s5.rstrdy", {31'd0, rdyA}, 32'd1);
    step();
    Reset = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        we[i]  = $urandom % 2;
        wa[i]  = 5'($urandom % dep(i));
        wd[i]  = $urandom;
        ra1[i] = ($urandom % 4 == 0) ? wa[i] : 5'($urandom % dep(i));
        ra2[i] = 5'($urandom % dep(i));
        rsv[i] = ($urandom % 3 == 0);
        rsa[i] = 5'($urandom % dep(i));
        clr[i] = ($urandom % 64 == 0);
      end
      Reset = ($urandom % 400 == 0);
      step();
    end
    Reset = 1'b0;
    idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
